// File: rtl/pika_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and
// image-format constants.
package pika_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CHK   = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler: collects BYTES_PER_WORD bytes little-endian into one word.
// word_next is the word including the byte being accepted this cycle, so the
// loader can register it on the same edge that takes the last byte.
module byte_assembler
  import pika_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_ready
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [BYTES_PER_WORD-1:0][7:0] lanes;
  logic [BYTES_PER_WORD-1:0][7:0] merged;
  logic [IDX_W-1:0]               byte_idx;

  // Merge the incoming byte into its lane; lane 0 holds bits 7:0.
  always_comb begin
    merged = lanes;
    if (byte_en) merged[byte_idx] = byte_in;
  end

  assign word_next  = merged;
  assign word_ready = byte_en && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

  // Lane storage and byte index; partial words are held across stalls.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lanes    <= '0;
      byte_idx <= '0;
    end else if (byte_en) begin
      lanes    <= merged;
      byte_idx <= byte_idx + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte image, writes it word by word
// into instrMem's test port from address 0 and holds the CPU in reset until
// the image is complete.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import pika_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [DATA_W-1:0] imem_wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int          NW_W      = ADDR_W + 1;
  localparam logic [31:0] CAP_WORDS = 32'(1) << ADDR_W;

  state_t          state;
  logic [7:0]      cnt_lo;
  logic [NW_W-1:0] n_words;
  logic [NW_W-1:0] words;
  logic [15:0]     hdr_count;
  logic            hdr_bad;
  logic            xfer;
  logic            start_ok;
  logic            byte_en;
  logic [31:0]     word_next;
  logic            word_ready;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign xfer      = rx_valid && rx_ready;
  assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
  assign byte_en   = xfer && (state == DATA);
  assign hdr_count = {rx_data, cnt_lo};
  assign hdr_bad   = (hdr_count == 16'd0) || ({16'd0, hdr_count} > CAP_WORDS);

  byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_en    (byte_en),
    .byte_in    (rx_data),
    .word_next  (word_next),
    .word_ready (word_ready)
  );

  // Loader FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rx_ready     <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      cnt_lo       <= '0;
      n_words      <= '0;
      words        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      imem_wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= HDR0;
            rx_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words        <= '0;
            imem_wr_addr <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end
        end
        HDR0: begin
          if (xfer) begin
            cnt_lo <= rx_data;
            state  <= HDR1;
          end
        end
        HDR1: begin
          if (xfer) begin
            if (hdr_bad) begin
              state    <= ERR;
              rx_ready <= 1'b0;
              load_err <= 1'b1;
              cpu_hold <= 1'b1;
            end else begin
              n_words <= NW_W'(hdr_count);
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            if (word_ready) begin
              state        <= WRITE;
              rx_ready     <= 1'b0;
              imem_wr_en   <= 1'b1;
              imem_wr_data <= DATA_W'(word_next);
            end
          end
        end
        WRITE: begin
          // Address advances after each write, wrapping to 0 after a full
          // memory; the word counter is one bit wider so N=2^ADDR_W ends.
          words        <= words + 1'b1;
          imem_wr_addr <= imem_wr_addr + 1'b1;
          if ((words + 1'b1) == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= CHK;
            rx_ready <= 1'b1;
`else
            state     <= DONE;
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
`endif
          end else begin
            state    <= DATA;
            rx_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with an image-level reference model.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int LAT_BASE = 3;
`else
  localparam int LAT_BASE = 2;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [DATA_W-1:0] imem_wr_data;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every write strobe is logged for later comparison.
  logic [ADDR_W-1:0] wa_q[$];
  logic [DATA_W-1:0] wd_q[$];
  always @(negedge clk) begin
    if (imem_wr_en) begin
      wa_q.push_back(imem_wr_addr);
      wd_q.push_back(imem_wr_data);
    end
  end

  int errors = 0;
  int checks = 0;

  logic [7:0]  img[$];
  logic [31:0] exp_w[$];
  int          t0, t_done, stalls;
  bit          done_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (load_done && !done_seen) begin
      done_seen = 1'b1;
      t_done    = cyc;
    end
  endtask

  // Reference: decode the image by its format rules. Returns 1 if the load
  // should end in DONE; exp_w gets every word that should be written.
  function automatic int model();
    int n;
    logic [7:0] x;
    exp_w.delete();
    x = 8'h00;
    n = int'(img[0]) + 256 * int'(img[1]);
    if (n == 0 || n > (1 << ADDR_W)) return 0;
    for (int i = 0; i < n; i++) begin
      exp_w.push_back({img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]});
      for (int k = 0; k < 4; k++) x = x ^ img[2+4*i+k];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (img.size() < 3 + 4*n) return 0;
    return (img[2+4*n] == x) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  // Appends the trailing checksum byte when that feature is built in.
  task automatic seal_img(input bit good);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < img.size(); i++) x = x ^ img[i];
    img.push_back(good ? x : (x ^ 8'h5a));
`else
    if (!good) $display("note: checksum disabled, bad-checksum request ignored");
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    done_seen = 1'b0;
    t0 = cyc;
  endtask

  // mode 0: valid held high, 1: valid every other cycle, 2: random gaps
  task automatic feed(input int mode, input int n_bytes, output int acc);
    int  guard;
    bit  gap, rdy;
    acc    = 0;
    guard  = 0;
    stalls = 0;
    while (acc < n_bytes && guard < 5000) begin
      case (mode)
        1:       gap = (guard % 2) == 1;
        2:       gap = $urandom_range(0, 9) < 3;
        default: gap = 1'b0;
      endcase
      if (gap) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data  = img[acc];
      end
      rdy = rx_ready;
      tick();
      if (rx_valid && rdy) acc++;
      if (!rx_valid && rdy) stalls++;
      guard++;
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input int mode);
    int ok, acc, base, nw, n;
    ok   = model();
    base = wa_q.size();
    pulse_start();
    feed(mode, img.size(), acc);
    chk({tag, ".accepted"}, acc, img.size());
    repeat (8) tick();
    nw = wa_q.size() - base;
    n  = exp_w.size();
    chk({tag, ".nwrites"}, nw, n);
    for (int i = 0; i < n && i < nw; i++) begin
      chk($sformatf("%s.addr%0d", tag, i), 32'(wa_q[base+i]), 32'(i % (1 << ADDR_W)));
      chk($sformatf("%s.data%0d", tag, i), wd_q[base+i], exp_w[i]);
    end
    chk({tag, ".done"}, load_done, ok != 0);
    chk({tag, ".err"}, load_err, ok == 0);
    chk({tag, ".hold"}, cpu_hold, ok == 0);
    chk({tag, ".ready"}, rx_ready, 0);
    chk({tag, ".addr_end"}, 32'(imem_wr_addr), 32'(n % (1 << ADDR_W)));
    if (ok != 0)
      chk({tag, ".latency"}, done_seen ? (t_done - t0) : -1, LAT_BASE + 5*n + stalls);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".rx_ready"}, rx_ready, 0);
    chk({tag, ".wr_en"}, imem_wr_en, 0);
    chk({tag, ".wr_addr"}, 32'(imem_wr_addr), 0);
    chk({tag, ".wr_data"}, imem_wr_data, 0);
    chk({tag, ".cpu_hold"}, cpu_hold, 1);
    chk({tag, ".done"}, load_done, 0);
    chk({tag, ".err"}, load_err, 0);
  endtask

  task automatic happy_img();
    logic [7:0] b[10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                          8'h93, 8'h05, 8'h20, 8'h00};
    img.delete();
    foreach (b[i]) img.push_back(b[i]);
    seal_img(1'b1);
  endtask

  task automatic rand_img(input int n, input bit good);
    img.delete();
    img.push_back(8'(n));
    img.push_back(8'(n >> 8));
    for (int i = 0; i < 4*n; i++) img.push_back(8'($urandom));
    seal_img(good);
  endtask

  initial begin
    int acc;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();
    check_reset_vals("por");
    reset = 1'b0;
    tick();

    happy_img();
    run_load("happy", 0);
    chk("happy.word0", exp_w[0], 32'h00100513);
    chk("happy.word1", exp_w[1], 32'h00200593);

    happy_img();
    run_load("bubble", 1);

    img.delete();
    img.push_back(8'h00); img.push_back(8'h00);
    run_load("hdr_zero", 0);
    img.delete();
    img.push_back(8'h01); img.push_back(8'h01);
    run_load("hdr_257", 0);

    img.delete();
    img.push_back(8'h00); img.push_back(8'h01);
    for (int i = 0; i < 256; i++) begin
      img.push_back(8'(i)); img.push_back(8'h00);
      img.push_back(8'h00); img.push_back(8'h00);
    end
    seal_img(1'b1);
    run_load("full", 0);

    // Reset after two header bytes and six data bytes.
    happy_img();
    pulse_start();
    feed(0, 8, acc);
    chk("midrst.accepted", acc, 8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("midrst");
    tick();
    happy_img();
    run_load("after_rst", 0);

    for (int r = 0; r < 6; r++) begin
      rand_img(int'($urandom_range(1, 16)), 1'b1);
      run_load($sformatf("rand%0d", r), 2);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    img.delete();
    img.push_back(8'h01); img.push_back(8'h00);
    img.push_back(8'h01); img.push_back(8'h02);
    img.push_back(8'h03); img.push_back(8'h04);
    img.push_back(8'h04);
    run_load("csum_good", 0);
    img[6] = 8'h05;
    run_load("csum_bad", 0);
    rand_img(int'($urandom_range(1, 8)), 1'b0);
    run_load("csum_rand_bad", 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory injection port. Loads a program image into instrMem's test port.
- Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to sequential word addresses from 0.
- Holds the CPU in reset until the image is complete, then releases it.
- Sits between the host/UART byte source and instrMem, alongside the PikaRISC core in the top level.

Parameters:
- ADDR_W, 8, imem word-address width; capacity is 2^ADDR_W words (256).
- DATA_W, 32, instruction word width; fixed at 32, byte assembly assumes 4 bytes per word.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- rx_valid  input  1  byte source has a byte.
- rx_data  input  8  byte value.
- rx_ready  output  1  loader accepts a byte this cycle.
- imem_wr_en  output  1  one-cycle write strobe to the instrMem test port.
- imem_wr_addr  output  ADDR_W  word address for the write.
- imem_wr_data  output  DATA_W  word to write.
- cpu_hold  output  1  high keeps PikaRISC in reset.
- load_done  output  1  level; image loaded successfully.
- load_err  output  1  level; image rejected.

Behaviour:
- Reset values: rx_ready=0, imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, cpu_hold=1, load_done=0, load_err=0, state=IDLE.
- Byte transfer occurs when rx_valid && rx_ready on a clock edge.
- rx_ready=1 only in HDR0, HDR1, DATA and CHK; it is 0 in all other states.
- Image format: 16-bit little-endian word count N, then N*4 data bytes, each word little-endian (first byte goes to bits 7:0).
- States and transitions:
  - IDLE: on start, go to HDR0, set cpu_hold=1, clear load_done and load_err, reset word counter and imem_wr_addr to 0.
  - HDR0: accept count[7:0], go to HDR1.
  - HDR1: accept count[15:8]. If N==0 or N>2^ADDR_W, go to ERR. Otherwise go to DATA with byte index 0.
  - DATA: accept a byte into lane byte_idx and increment byte_idx. When the 4th byte is accepted, go to WRITE.
  - WRITE: one cycle. imem_wr_en=1, imem_wr_addr=current word index, imem_wr_data=assembled word. Next cycle, increment the word index. If words written==N, go to DONE (or CHK if the checksum feature is enabled); otherwise go to DATA.
  - DONE: load_done=1, cpu_hold=0. Stay until start, which begins a new load.
  - ERR: load_err=1, cpu_hold=1. Stay until start.
- Latency:
  - The write strobe is asserted exactly one cycle after the 4th byte of a word is accepted.
  - cpu_hold falls on the cycle DONE is entered.
  - Minimum load time is 2 + 5N cycles with rx_valid held high.
- Bubbles: rx_valid gaps stall without penalty, and partial-word state is held.
- Word counter is ADDR_W+1 bits so N=2^ADDR_W completes without aliasing. imem_wr_addr wraps to 0 after the last word, but no further write is issued.
- start is ignored in HDR0, HDR1, DATA, WRITE and CHK.
- Reset mid-load: return to IDLE with all reset values. Words already written stay in memory, and cpu_hold remains 1.
- imem_wr_addr and imem_wr_data hold their last values outside WRITE; only imem_wr_en qualifies a write.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all data bytes (header excluded) is kept and cleared on start.
  - After the last WRITE, state CHK accepts one more byte.
  - If that byte equals the XOR, go to DONE; otherwise go to ERR.
  - Minimum load time becomes 3 + 5N cycles.
- Undefined:
  - No CHK state and no checksum register.
  - The last WRITE goes directly to DONE.

Decomposition:
- Shared package pika_loader_pkg holds:
  - The state enum (IDLE, HDR0, HDR1, DATA, WRITE, CHK, DONE, ERR).
  - BYTES_PER_WORD=4.
  - The header length constant HDR_BYTES=2.
- One sub-module is natural: byte_assembler. It covers the byte-index counter, 4-lane shift/merge into a 32-bit word, and the word_ready flag, and it is cleared by the FSM.

Test Plan:
- Happy path, 2 words:
  - Stimulus: start, then bytes 02 00 13 05 10 00 93 05 20 00 with rx_valid held high.
  - Expected: wr_en pulses at addr 0 data 0x00100513 and at addr 1 data 0x00200593; load_done=1 and cpu_hold=0 at cycle 12.
- Bubbles: same image with rx_valid low on every other cycle.
  - Expected: identical writes and data; done is delayed only by the idle cycles; no duplicated bytes.
- Bad header:
  - Count 00 00 gives load_err=1, no write, cpu_hold=1.
  - Count 01 01 (257) with ADDR_W=8 gives the same result.
- Full capacity: N=256 (00 01), word i = i.
  - Expected: 256 writes at addresses 0..255 and load_done=1; addr wraps to 0 with no 257th strobe.
- Reset mid-load: assert reset after 6 data bytes.
  - Expected: all outputs return to reset values; a new start plus a full image then loads correctly from addr 0.
- Checksum (IMEM_LOADER_CHECKSUM_EN defined): 1 word 01 02 03 04.
  - Trailing 04 gives DONE.
  - Trailing 05 gives ERR with cpu_hold=1, after the write to addr 0 has already occurred.
